// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The producer drives operands through master; the adder uses slave.
interface full_adder_if #(
  parameter int unsigned WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             c;
  logic             ovf;
  logic             out_valid;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    input  sum,
    input  c,
    input  ovf,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    output sum,
    output c,
    output ovf,
    output out_valid
  );
endinterface

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder with a registered sum, carry-out and signed overflow.
// One cycle of latency, one operation per cycle, no backpressure.
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  full_adder_if.slave bus_io
);

  // k[i] is the carry into bit i; k[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] s;

  assign k[0] = bus_io.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_cell
    logic p;
    logic g;
    // Two half adders: first on a/b, second folds in the incoming carry.
    assign p      = bus_io.a[i] ^ bus_io.b[i];
    assign g      = bus_io.a[i] & bus_io.b[i];
    assign s[i]   = p ^ k[i];
    assign k[i+1] = g | (p & k[i]);
  end

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             c_d, c_q;
  logic             ovf_d, ovf_q;
  logic             out_valid_d, out_valid_q;

  always_comb begin
    sum_d       = sum_q;
    c_d         = c_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    if (bus_io.in_valid) begin
      sum_d       = s;
      c_d         = k[WIDTH];
      ovf_d       = k[WIDTH] ^ k[WIDTH-1];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      c_q         <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      c_q         <= c_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus_io.sum       = sum_q;
  assign bus_io.c         = c_q;
  assign bus_io.ovf       = ovf_q;
  assign bus_io.out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: a WIDTH=1 and a WIDTH=8 instance driven from
// a vector table plus hand-written reset, hold and mid-stream reset sequences.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  full_adder_if #(.WIDTH(1)) bus1 ();
  full_adder_if #(.WIDTH(8)) bus8 ();

  full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus_io(bus1));
  full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus_io(bus8));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       w8;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       c;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive operands into one instance; the other instance is idle.
  task automatic drive(input logic w8, input logic vld, input logic [7:0] a,
                       input logic [7:0] b, input logic cin);
    bus1.in_valid = vld & ~w8;
    bus1.a        = a[0];
    bus1.b        = b[0];
    bus1.cin      = cin;
    bus8.in_valid = vld & w8;
    bus8.a        = a;
    bus8.b        = b;
    bus8.cin      = cin;
  endtask

  task automatic check_out(input logic w8, input string tag, input logic [7:0] sum,
                           input logic c, input logic ovf, input logic ov);
    if (w8) begin
      check({tag, " w8 sum"}, {56'd0, bus8.sum}, {56'd0, sum});
      check({tag, " w8 c"}, {63'd0, bus8.c}, {63'd0, c});
      check({tag, " w8 ovf"}, {63'd0, bus8.ovf}, {63'd0, ovf});
      check({tag, " w8 out_valid"}, {63'd0, bus8.out_valid}, {63'd0, ov});
    end else begin
      check({tag, " w1 sum"}, {63'd0, bus1.sum}, {63'd0, sum[0]});
      check({tag, " w1 c"}, {63'd0, bus1.c}, {63'd0, c});
      check({tag, " w1 ovf"}, {63'd0, bus1.ovf}, {63'd0, ovf});
      check({tag, " w1 out_valid"}, {63'd0, bus1.out_valid}, {63'd0, ov});
    end
  endtask

  initial begin
    // WIDTH=1 truth table; ovf = cin ^ c.
    vecs.push_back('{1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'd0, 8'd1, 1'b0, 8'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 8'd1, 8'd1, 1'b0, 8'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 8'd0, 8'd0, 1'b1, 8'd1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 8'd1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0});
    // WIDTH=8 ripple, maxima and signed overflow cases.
    vecs.push_back('{1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0});

    // Reset has priority over in_valid on both instances.
    rst = 1'b1;
    bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1;
    bus8.in_valid = 1'b1; bus8.a = 8'd1; bus8.b = 8'd1; bus8.cin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_out(1'b0, "reset", 8'd0, 1'b0, 1'b0, 1'b0);
      check_out(1'b1, "reset", 8'd0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;

    // Back-to-back table: each result checked one edge after its operands.
    foreach (vecs[i]) begin
      drive(vecs[i].w8, 1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      step();
      check_out(vecs[i].w8, $sformatf("vec%0d", i), vecs[i].sum, vecs[i].c, vecs[i].ovf, 1'b1);
    end

    // Hold: idle cycles with changing operands keep the last result.
    drive(1'b1, 1'b1, 8'd3, 8'd4, 1'b0);
    step();
    check_out(1'b1, "hold load", 8'd7, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'd9, 8'd9, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out(1'b1, $sformatf("hold%0d", i), 8'd7, 1'b0, 1'b0, 1'b0);
    end

    // Mid-stream reset on the third consecutive valid cycle.
    drive(1'b1, 1'b1, 8'd10, 8'd20, 1'b0);
    step();
    check_out(1'b1, "mid op1", 8'd30, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'hF0, 8'h20, 1'b0);
    step();
    check_out(1'b1, "mid op2", 8'h10, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'd5, 8'd5, 1'b0);
    rst = 1'b1;
    step();
    check_out(1'b1, "mid rst", 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 8'd6, 8'd7, 1'b0);
    step();
    check_out(1'b1, "mid resume", 8'd13, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    step();
    check_out(1'b1, "mid idle", 8'd13, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Parameterized ripple-carry adder: sum/carry = a + b + cin, captured in an output register with a valid flag.
- Default WIDTH=1 gives the classic 1-bit full adder (sum, carry-out) with one cycle of latency.
- Used as the basic arithmetic cell in the team's adder/ALU datapaths. Wider instances chain WIDTH bit-cells internally.

Parameters:
- WIDTH, 1, operand and sum width in bits. Legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid this cycle. Tie to 1 for free-running use.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- sum  output  WIDTH  registered sum bits.
- c  output  1  registered carry-out from the MSB.
- ovf  output  1  registered signed overflow flag.
- out_valid  output  1  sum/c/ovf updated by the previous cycle's in_valid.

Behaviour:
- Reset: on a rising clk with rst=1:
  - sum=0, c=0, ovf=0, out_valid=0.
  - rst has priority over in_valid.
  - Asserting rst mid-stream discards the operation being captured.
- Datapath structure:
  - Each bit i is a full-adder cell built from two half adders: s_i = a_i^b_i^k_i; k_{i+1} = (a_i&b_i) | ((a_i^b_i)&k_i); k_0 = cin.
  - Carry chain is pure combinational ripple.
- Capture: on a rising clk with rst=0 and in_valid=1:
  - {c, sum} <= a + b + cin, computed at full precision (WIDTH+1 bits, no truncation of the carry).
  - ovf <= k_{WIDTH-1} ^ k_WIDTH, i.e. carry into MSB XOR carry out.
  - For WIDTH=1 this gives ovf = cin ^ c.
  - out_valid <= 1.
- Idle: on a rising clk with rst=0 and in_valid=0:
  - sum, c and ovf hold their previous values.
  - out_valid <= 0.
- Latency:
  - Exactly 1 clock from operand capture to result.
  - Full throughput of one operation per cycle.
  - Back-to-back in_valid produces back-to-back out_valid.
- No backpressure. The consumer must sample the result while out_valid=1.
- Inputs are sampled only at the clock edge. Input changes between edges have no effect on the outputs.
- Boundary cases:
  - All-ones operands with cin=1 produce sum=all-ones and c=1 (wrap-around plus carry).
  - All-zeros operands with cin=0 produce sum=0, c=0, ovf=0.
- No X-propagation masking: X inputs with in_valid=1 may yield X outputs. Outputs are never X after reset.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, a=1, b=1, cin=1 -> sum=0, c=0, ovf=0, out_valid=0 throughout.
- WIDTH=1 truth table: apply (a,b,cin) in the sequence 000, 100, 010, 110, 001, 101, 011, 111, one per cycle with in_valid=1.
  - Required (sum,c) one cycle later: 00, 10, 10, 01, 10, 01, 01, 11.
  - out_valid=1 on each of those cycles.
- WIDTH=8 carry ripple: a=0xFF, b=0x00, cin=1 -> sum=0x00, c=1, ovf=0. Then a=0x7F, b=0x01, cin=0 -> sum=0x80, c=0, ovf=1.
- WIDTH=8 maximum: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, c=1, ovf=0. Then a=0x80, b=0x80, cin=0 -> sum=0x00, c=1, ovf=1.
- Hold: after a=3, b=4, cin=0 (sum=7), drive in_valid=0 with a=9, b=9 for 3 cycles -> sum stays 7, out_valid=0.
- Reset mid-stream: in_valid=1 on consecutive cycles, rst=1 on the third cycle -> outputs return to 0 and out_valid=0 on the next edge. Capture resumes the cycle after rst falls.
